// File: rtl/led_frame_shifter.sv
// Serialises captured display frames MSB-first onto a 74HC595-style chain (data/clock/latch),
// buffering one pending frame, and blinks the board via oe_n while gameover is high.
module led_frame_shifter #(
  parameter int unsigned FRAME_W   = 23,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned LATCH_W   = 2,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               frame_vld,
  input  logic               gameover,
  output logic               ser_data,
  output logic               ser_clk,
  output logic               ser_latch,
  output logic               oe_n,
  output logic               busy,
  output logic               overflow
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(FRAME_W + 1);
  localparam int unsigned LAT_W = (LATCH_W > 1) ? $clog2(LATCH_W) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [FRAME_W-1:0] r_shreg, w_shreg_nxt;
  logic [FRAME_W-1:0] r_pend, w_pend_nxt;
  logic               r_pend_vld, w_pend_vld_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic               r_phase, w_phase_nxt;
  logic [BIT_W-1:0]   r_bit, w_bit_nxt;
  logic [LAT_W-1:0]   r_lat, w_lat_nxt;
  logic [BLK_W-1:0]   r_blink, w_blink_nxt;
  logic               r_vld_d;
  logic               r_ser_data, w_ser_data_nxt;
  logic               r_ser_clk, w_ser_clk_nxt;
  logic               r_ser_latch, w_ser_latch_nxt;
  logic               r_oe_n, w_oe_n_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_overflow, w_overflow_nxt;
  logic               w_edge;

  assign w_edge = frame_vld & ~r_vld_d;

  // State and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_pend      <= '0;
      r_pend_vld  <= 1'b0;
      r_div       <= '0;
      r_phase     <= 1'b0;
      r_bit       <= '0;
      r_lat       <= '0;
      r_blink     <= '0;
      r_vld_d     <= 1'b0;
      r_ser_data  <= 1'b0;
      r_ser_clk   <= 1'b0;
      r_ser_latch <= 1'b0;
      r_oe_n      <= 1'b0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shreg     <= w_shreg_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_div       <= w_div_nxt;
      r_phase     <= w_phase_nxt;
      r_bit       <= w_bit_nxt;
      r_lat       <= w_lat_nxt;
      r_blink     <= w_blink_nxt;
      r_vld_d     <= frame_vld;
      r_ser_data  <= w_ser_data_nxt;
      r_ser_clk   <= w_ser_clk_nxt;
      r_ser_latch <= w_ser_latch_nxt;
      r_oe_n      <= w_oe_n_nxt;
      r_busy      <= w_busy_nxt;
      r_overflow  <= w_overflow_nxt;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_shreg_nxt     = r_shreg;
    w_pend_nxt      = r_pend;
    w_pend_vld_nxt  = r_pend_vld;
    w_div_nxt       = r_div;
    w_phase_nxt     = r_phase;
    w_bit_nxt       = r_bit;
    w_lat_nxt       = r_lat;
    w_blink_nxt     = r_blink;
    w_ser_data_nxt  = 1'b0;
    w_ser_clk_nxt   = 1'b0;
    w_ser_latch_nxt = 1'b0;
    w_oe_n_nxt      = r_oe_n;
    w_overflow_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_pend_vld || w_edge) begin
          if (r_pend_vld) begin
            w_shreg_nxt    = r_pend;
            w_pend_vld_nxt = w_edge;
            if (w_edge) w_pend_nxt = frame_in;
          end else begin
            w_shreg_nxt = frame_in;
          end
          w_state_nxt    = S_SHIFT;
          w_div_nxt      = '0;
          w_phase_nxt    = 1'b0;
          w_bit_nxt      = '0;
          w_ser_data_nxt = w_shreg_nxt[FRAME_W-1];
        end
      end

      S_SHIFT: begin
        w_ser_data_nxt = r_ser_data;
        w_ser_clk_nxt  = r_ser_clk;
        if (r_div == DIV_W'(CLK_DIV - 1)) begin
          w_div_nxt = '0;
          if (!r_phase) begin
            w_phase_nxt   = 1'b1;
            w_ser_clk_nxt = 1'b1;
          end else if (r_bit == BIT_W'(FRAME_W - 1)) begin
            w_state_nxt     = S_LATCH;
            w_lat_nxt       = '0;
            w_ser_clk_nxt   = 1'b0;
            w_ser_data_nxt  = 1'b0;
            w_ser_latch_nxt = 1'b1;
          end else begin
            // Rotate so the next bit sits in the MSB; data only moves at the falling edge
            w_bit_nxt      = r_bit + BIT_W'(1);
            w_shreg_nxt    = {r_shreg[FRAME_W-2:0], r_shreg[FRAME_W-1]};
            w_ser_data_nxt = r_shreg[FRAME_W-2];
            w_ser_clk_nxt  = 1'b0;
            w_phase_nxt    = 1'b0;
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end

      S_LATCH: begin
        w_ser_latch_nxt = 1'b1;
        if (r_lat == LAT_W'(LATCH_W - 1)) begin
          w_state_nxt     = S_IDLE;
          w_ser_latch_nxt = 1'b0;
        end else begin
          w_lat_nxt = r_lat + LAT_W'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // A strobe while busy parks in the single pending slot; newest wins
    if ((r_state != S_IDLE) && w_edge) begin
      w_pend_nxt     = frame_in;
      w_pend_vld_nxt = 1'b1;
      w_overflow_nxt = r_pend_vld;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);

    if (!gameover) begin
      w_blink_nxt = '0;
      w_oe_n_nxt  = 1'b0;
    end else if (r_blink == BLK_W'(BLINK_DIV - 1)) begin
      w_blink_nxt = '0;
      w_oe_n_nxt  = ~r_oe_n;
    end else begin
      w_blink_nxt = r_blink + BLK_W'(1);
    end
  end

  assign ser_data  = r_ser_data;
  assign ser_clk   = r_ser_clk;
  assign ser_latch = r_ser_latch;
  assign oe_n      = r_oe_n;
  assign busy      = r_busy;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_led_frame_shifter.sv
// Directed self-checking bench for led_frame_shifter (FRAME_W=23, CLK_DIV=2, LATCH_W=2, BLINK_DIV=8).
module tb_led_frame_shifter;

  logic        clk;
  logic        rst;
  logic [22:0] frame_in;
  logic        frame_vld;
  logic        gameover;
  logic        ser_data, ser_clk, ser_latch, oe_n, busy, overflow;

  int total = 0;
  int bad   = 0;

  // Observation state, updated once per cycle by tick()
  int          cyc = 0;
  int          rise_cnt, latch_cycles, latch_pulses, busy_cycles, busy_rises;
  int          ovf_cnt, low_run, last_gap;
  int          first_rise, last_rise, first_latch, busy_first, ovf_first;
  logic [22:0] bits;
  logic [22:0] frames[$];
  logic        prev_clk, prev_latch, prev_busy;

  led_frame_shifter #(
    .FRAME_W(23), .CLK_DIV(2), .LATCH_W(2), .BLINK_DIV(8)
  ) dut (
    .clk(clk), .rst(rst), .frame_in(frame_in), .frame_vld(frame_vld), .gameover(gameover),
    .ser_data(ser_data), .ser_clk(ser_clk), .ser_latch(ser_latch), .oe_n(oe_n),
    .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_mon();
    rise_cnt = 0; latch_cycles = 0; latch_pulses = 0; busy_cycles = 0; busy_rises = 0;
    ovf_cnt = 0; low_run = 0; last_gap = -1;
    first_rise = -1; last_rise = -1; first_latch = -1; busy_first = -1; ovf_first = -1;
    bits = '0; frames.delete();
    prev_clk = ser_clk; prev_latch = ser_latch; prev_busy = busy;
  endtask

  // Advance to the next falling edge and record what the chain would see
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (ser_clk && !prev_clk) begin
      rise_cnt++;
      bits = {bits[21:0], ser_data};
      if (first_rise < 0) first_rise = cyc;
      last_rise = cyc;
    end
    if (ser_latch) begin
      latch_cycles++;
      if (!prev_latch) begin
        latch_pulses++;
        frames.push_back(bits);
        if (first_latch < 0) first_latch = cyc;
      end
    end
    if (busy) begin
      busy_cycles++;
      if (!prev_busy) begin
        busy_rises++;
        if (busy_first < 0) busy_first = cyc;
        if (busy_rises > 1) last_gap = low_run;
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    if (overflow) begin
      ovf_cnt++;
      if (ovf_first < 0) ovf_first = cyc;
    end
    prev_clk = ser_clk; prev_latch = ser_latch; prev_busy = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_in = '0; frame_vld = 1'b0; gameover = 1'b0;
    repeat (3) tick();
    total++; if (ser_data !== 1'b0)  begin bad++; $display("FAIL reset_ser_data: got %b want 0", ser_data); end
    total++; if (ser_clk !== 1'b0)   begin bad++; $display("FAIL reset_ser_clk: got %b want 0", ser_clk); end
    total++; if (ser_latch !== 1'b0) begin bad++; $display("FAIL reset_ser_latch: got %b want 0", ser_latch); end
    total++; if (oe_n !== 1'b0)      begin bad++; $display("FAIL reset_oe_n: got %b want 0", oe_n); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int c0;
    clr_mon();
    tick(); c0 = cyc; frame_in = 23'h400001; frame_vld = 1'b1;
    tick(); frame_vld = 1'b0; frame_in = 23'h7FFFFF;
    repeat (110) tick();
    total++; if (rise_cnt != 23) begin bad++; $display("FAIL single_rises: got %0d want 23", rise_cnt); end
    total++; if (frames.size() < 1 || frames[0] !== 23'h400001) begin
      bad++; $display("FAIL single_bits: got %h want 400001", frames.size() > 0 ? frames[0] : 23'h0);
    end
    total++; if (latch_cycles != 2 || latch_pulses != 1) begin
      bad++; $display("FAIL single_latch: got %0d cycles/%0d pulses want 2/1", latch_cycles, latch_pulses);
    end
    total++; if (busy_cycles != 94) begin bad++; $display("FAIL single_busy_len: got %0d want 94", busy_cycles); end
    total++; if (busy_first != c0 + 1) begin bad++; $display("FAIL single_busy_start: got %0d want %0d", busy_first, c0 + 1); end
    total++; if (first_rise - busy_first != 2) begin
      bad++; $display("FAIL single_first_rise: got offset %0d want 2", first_rise - busy_first);
    end
    total++; if (first_latch - last_rise != 2) begin
      bad++; $display("FAIL single_latch_pos: got offset %0d want 2", first_latch - last_rise);
    end
    total++; if (busy !== 1'b0 || ser_data !== 1'b0 || ser_clk !== 1'b0) begin
      bad++; $display("FAIL single_idle_out: got busy=%b data=%b clk=%b want 0", busy, ser_data, ser_clk);
    end
  endtask

  task automatic test_two_cycle();
    clr_mon();
    tick(); frame_in = 23'h2AAAAA; frame_vld = 1'b1;
    tick();
    tick(); frame_vld = 1'b0;
    repeat (110) tick();
    total++; if (rise_cnt != 23) begin bad++; $display("FAIL two_cycle_rises: got %0d want 23", rise_cnt); end
    total++; if (latch_pulses != 1) begin bad++; $display("FAIL two_cycle_latches: got %0d want 1", latch_pulses); end
    total++; if (frames.size() < 1 || frames[0] !== 23'h2AAAAA) begin
      bad++; $display("FAIL two_cycle_bits: got %h want 2aaaaa", frames.size() > 0 ? frames[0] : 23'h0);
    end
    total++; if (ovf_cnt != 0) begin bad++; $display("FAIL two_cycle_overflow: got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_back_to_back();
    clr_mon();
    tick(); frame_in = 23'h000007; frame_vld = 1'b1;
    tick(); frame_vld = 1'b0;
    repeat (19) tick();
    frame_in = 23'h7FFFF8; frame_vld = 1'b1;
    tick(); frame_vld = 1'b0; frame_in = 23'h155555;
    repeat (200) tick();
    total++; if (frames.size() != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", frames.size()); end
    total++; if (frames.size() < 2 || frames[0] !== 23'h000007 || frames[1] !== 23'h7FFFF8) begin
      bad++; $display("FAIL b2b_frames: got %h,%h want 000007,7ffff8",
                      frames.size() > 0 ? frames[0] : 23'h0, frames.size() > 1 ? frames[1] : 23'h0);
    end
    total++; if (last_gap != 1) begin bad++; $display("FAIL b2b_gap: got %0d want 1", last_gap); end
    total++; if (busy_cycles != 188) begin bad++; $display("FAIL b2b_busy: got %0d want 188", busy_cycles); end
    total++; if (ovf_cnt != 0) begin bad++; $display("FAIL b2b_overflow: got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_overflow();
    int c0;
    clr_mon();
    tick(); c0 = cyc; frame_in = 23'h123456; frame_vld = 1'b1;
    tick(); frame_vld = 1'b0;
    repeat (19) tick();
    frame_in = 23'h654321; frame_vld = 1'b1;
    tick(); frame_vld = 1'b0;
    repeat (19) tick();
    frame_in = 23'h0F0F0F; frame_vld = 1'b1;
    tick(); frame_vld = 1'b0; frame_in = 23'h000000;
    repeat (200) tick();
    total++; if (ovf_cnt != 1) begin bad++; $display("FAIL ovf_count: got %0d want 1", ovf_cnt); end
    total++; if (ovf_first != c0 + 41) begin bad++; $display("FAIL ovf_when: got %0d want %0d", ovf_first, c0 + 41); end
    total++; if (frames.size() != 2 || frames[0] !== 23'h123456 || frames[1] !== 23'h0F0F0F) begin
      bad++; $display("FAIL ovf_frames: got n=%0d %h,%h want 2 123456,0f0f0f", frames.size(),
                      frames.size() > 0 ? frames[0] : 23'h0, frames.size() > 1 ? frames[1] : 23'h0);
    end
  endtask

  task automatic test_blink();
    logic exp;
    tick(); gameover = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp = ((k / 8) % 2) == 1;
      total++; if (oe_n !== exp) begin bad++; $display("FAIL blink_k%0d: got %b want %b", k, oe_n, exp); end
    end
    gameover = 1'b0;
    tick();
    total++; if (oe_n !== 1'b0) begin bad++; $display("FAIL blink_release: got %b want 0", oe_n); end
  endtask

  task automatic test_reset_mid();
    clr_mon();
    tick(); frame_in = 23'h5A5A5A; frame_vld = 1'b1;
    tick(); frame_vld = 1'b0;
    repeat (4) tick();
    frame_in = 23'h111111; frame_vld = 1'b1;
    tick(); frame_vld = 1'b0;
    for (int i = 0; i < 300 && rise_cnt < 10; i++) tick();
    total++; if (rise_cnt != 10) begin bad++; $display("FAIL rstmid_reach: got %0d rises want 10", rise_cnt); end
    rst = 1'b1;
    #1;
    total++; if ({ser_data, ser_clk, ser_latch, oe_n, busy, overflow} !== 6'b0) begin
      bad++; $display("FAIL rstmid_outputs: got %b want 000000", {ser_data, ser_clk, ser_latch, oe_n, busy, overflow});
    end
    repeat (3) tick();
    total++; if (latch_pulses != 0) begin bad++; $display("FAIL rstmid_nolatch: got %0d want 0", latch_pulses); end
    rst = 1'b0;
    clr_mon();
    repeat (10) tick();
    total++; if (busy_cycles != 0) begin bad++; $display("FAIL rstmid_pend_drop: got %0d busy cycles want 0", busy_cycles); end
    frame_in = 23'h3C3C3C; frame_vld = 1'b1;
    tick(); frame_vld = 1'b0;
    repeat (110) tick();
    total++; if (rise_cnt != 23) begin bad++; $display("FAIL rstmid_rises: got %0d want 23", rise_cnt); end
    total++; if (frames.size() != 1 || frames[0] !== 23'h3C3C3C) begin
      bad++; $display("FAIL rstmid_frame: got n=%0d %h want 1 3c3c3c", frames.size(), frames.size() > 0 ? frames[0] : 23'h0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_cycle();
    test_back_to_back();
    test_overflow();
    test_blink();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
